// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receiver for 8N1 frames, LSB first. The RX line is
// synchronised and oversampled. The receiver finds the falling edge of a
// start bit, confirms the start bit at its middle, then samples every data
// bit and the stop bit at mid-bit. A good frame updates RX_DATA with a
// one-cycle rx_valid pulse. A low stop bit produces a one-cycle frame_error
// pulse instead.
//
// Ports:
//   sysclk      - system clock; all logic runs on its rising edge
//   reset       - synchronous, active-high reset
//   enable      - receiver enable; when low the receiver is held in IDLE
//   UART_RX     - asynchronous serial input; the line idles high
//   RX_DATA     - last correctly framed byte; held until the next good frame
//   rx_valid    - one-cycle pulse when RX_DATA updates
//   frame_error - one-cycle pulse when the stop bit is sampled low
//   busy        - registered; high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] HALF_MAX  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_MAX  = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state;
    state_t state_next;

    logic              rx_meta;
    logic              rx_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_next;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_next;
    logic [7:0]        data_next;
    logic              valid_next;
    logic              ferr_next;

    // Two-flop synchroniser. It resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // The tick divider only runs outside IDLE. It is held at zero in IDLE, so
    // the bit timing is phase-aligned to the detected start edge.
    assign tick = (state != IDLE) && (div_cnt == DIV_MAX);

    always_comb begin
        if (state == IDLE || state_next == IDLE || tick) begin
            div_next = '0;
        end else begin
            div_next = div_cnt + 1'b1;
        end
    end

    // Next-state logic. In START, the decision is taken on the half-bit tick.
    // In DATA and STOP, decisions are taken on every full-bit tick. Because
    // STOP ends at mid-stop-bit, a back-to-back start edge is seen in time.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = RX_DATA;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            tick_next  = '0;
            bit_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        tick_next  = '0;
                        bit_next   = '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_MAX) begin
                            tick_next = '0;
                            bit_next  = '0;
                            // A line that is already high again was a glitch.
                            if (!rx_s) begin
                                state_next = DATA;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            tick_next = tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_MAX) begin
                            tick_next  = '0;
                            shift_next = {rx_s, shift_reg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state_next = STOP;
                            end else begin
                                bit_next = bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_next = tick_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_MAX) begin
                            tick_next = '0;
                            if (rx_s) begin
                                data_next  = shift_reg;
                                valid_next = 1'b1;
                                state_next = IDLE;
                            end else begin
                                ferr_next  = 1'b1;
                                state_next = WAIT_HIGH;
                            end
                        end else begin
                            tick_next = tick_cnt + 1'b1;
                        end
                    end
                end

                // A break condition holds the line low; wait for it to recover
                // so that the receiver does not re-trigger on it.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers. busy is registered from the next state so
    // that it lines up with the state register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            RX_DATA     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            div_cnt     <= div_next;
            tick_cnt    <= tick_next;
            bit_cnt     <= bit_next;
            shift_reg   <= shift_next;
            RX_DATA     <= data_next;
            rx_valid    <= valid_next;
            frame_error <= ferr_next;
            busy        <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Testbench for uart_receiver. It uses a 160-cycle bit period (DIV = 10).
// The stimulus process pushes the strobe it expects into a queue before it
// drives each frame. A monitor running on the falling clock edge pops that
// queue on every rx_valid or frame_error pulse and compares the result.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB = 160;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       sysclk;
    logic       reset;
    logic       enable;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    int   check_count;
    int   error_count;
    int   cycle;
    exp_t exp_q[$];
    int   valid_times[$];

    uart_receiver #(
        .CLK_FREQ   (1600000),
        .BAUD       (10000),
        .OVERSAMPLE (16)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .enable      (enable),
        .UART_RX     (UART_RX),
        .RX_DATA     (RX_DATA),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Free-running cycle counter, used to measure the spacing between strobes.
    always @(posedge sysclk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one 8N1 frame, LSB first, with the given stop level and bit period.
    // The line is left high when the task returns.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int cpb);
        UART_RX = 1'b0;
        repeat (cpb) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = data[i];
            repeat (cpb) @(negedge sysclk);
        end
        UART_RX = stop_val;
        repeat (cpb) @(negedge sysclk);
        UART_RX = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor. Every strobe must match the next expected event.
    always @(negedge sysclk) begin
        if (!reset && (rx_valid || frame_error)) begin
            exp_t e;
            if (rx_valid) valid_times.push_back(cycle);
            check_count++;
            if (rx_valid && frame_error) begin
                error_count++;
                $display("[TB] FAIL strobe_excl: rx_valid=1 frame_error=1, expected one only");
            end else if (exp_q.size() == 0) begin
                error_count++;
                $display("[TB] FAIL unexpected_strobe: rx_valid=%0b frame_error=%0b RX_DATA=0x%0h, expected none",
                         rx_valid, frame_error, RX_DATA);
            end else begin
                e = exp_q.pop_front();
                if (frame_error !== e.is_err || RX_DATA !== e.data) begin
                    error_count++;
                    $display("[TB] FAIL strobe: got err=%0b data=0x%0h, expected err=%0b data=0x%0h",
                             frame_error, RX_DATA, e.is_err, e.data);
                end
            end
        end
    end

    initial begin
        check_count = 0;
        error_count = 0;
        cycle       = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        UART_RX     = 1'b1;
        repeat (4) @(negedge sysclk);

        checkOutput("reset_rx_data", RX_DATA, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_frame_error", frame_error, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);

        // 1: single frame 0x55
        $display("[TB] test 1: frame 0x55");
        exp_q.push_back('{1'b0, 8'h55});
        fork
            applyStimulus(8'h55, 1'b1, CPB);
            begin
                repeat (800) @(negedge sysclk);
                checkOutput("t1_busy_mid", busy, 1'b1);
            end
        join
        repeat (200) @(negedge sysclk);
        waitDrain("t1_drain", 200);
        checkOutput("t1_busy_idle", busy, 1'b0);

        // 2: back-to-back 0xA3, 0x0F
        $display("[TB] test 2: back-to-back 0xA3 0x0F");
        valid_times.delete();
        exp_q.push_back('{1'b0, 8'hA3});
        exp_q.push_back('{1'b0, 8'h0F});
        applyStimulus(8'hA3, 1'b1, CPB);
        applyStimulus(8'h0F, 1'b1, CPB);
        repeat (200) @(negedge sysclk);
        waitDrain("t2_drain", 200);
        if (valid_times.size() == 2) begin
            int gap;
            gap = valid_times[1] - valid_times[0];
            checkOutput("t2_gap_ok", (gap >= 1595 && gap <= 1605), 1'b1);
        end else begin
            checkOutput("t2_valid_count", valid_times.size(), 2);
        end

        // 3: framing error on 0x3C, RX_DATA must keep 0x0F
        $display("[TB] test 3: framing error");
        exp_q.push_back('{1'b1, 8'h0F});
        applyStimulus(8'h3C, 1'b0, CPB);
        repeat (300) @(negedge sysclk);
        waitDrain("t3_drain", 200);
        checkOutput("t3_rx_data_held", RX_DATA, 8'h0F);
        checkOutput("t3_busy_idle", busy, 1'b0);

        // 4: 40-cycle glitch
        $display("[TB] test 4: glitch");
        UART_RX = 1'b0;
        repeat (20) @(negedge sysclk);
        checkOutput("t4_busy_rise", busy, 1'b1);
        repeat (20) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (60) @(negedge sysclk);
        checkOutput("t4_busy_fall", busy, 1'b0);
        repeat (200) @(negedge sysclk);

        // 5: reset during data bit 3 of 0xFF, then 0x81
        $display("[TB] test 5: reset mid-frame");
        fork
            applyStimulus(8'hFF, 1'b1, CPB);
            begin
                repeat (CPB * 4 + CPB / 2) @(negedge sysclk);
                reset = 1'b1;
                repeat (2) @(negedge sysclk);
                reset = 1'b0;
                @(negedge sysclk);
                checkOutput("t5_rx_data_reset", RX_DATA, 8'h00);
                checkOutput("t5_busy_reset", busy, 1'b0);
            end
        join
        repeat (200) @(negedge sysclk);
        exp_q.push_back('{1'b0, 8'h81});
        applyStimulus(8'h81, 1'b1, CPB);
        repeat (200) @(negedge sysclk);
        waitDrain("t5_drain", 200);

        // 6: disabled frame ignored, then a fast (154 cycles/bit) frame
        $display("[TB] test 6: enable and baud mismatch");
        enable = 1'b0;
        fork
            applyStimulus(8'h12, 1'b1, CPB);
            begin
                repeat (800) @(negedge sysclk);
                checkOutput("t6_busy_disabled", busy, 1'b0);
            end
        join
        repeat (100) @(negedge sysclk);
        checkOutput("t6_rx_data_kept", RX_DATA, 8'h81);
        enable = 1'b1;
        repeat (50) @(negedge sysclk);
        exp_q.push_back('{1'b0, 8'h34});
        applyStimulus(8'h34, 1'b1, 154);
        repeat (200) @(negedge sysclk);
        waitDrain("t6_drain", 200);
        checkOutput("t6_busy_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It is the receive-side counterpart of the board's UART transmit path and uses 8N1 framing, LSB first. It oversamples the asynchronous RX line, finds the start bit, samples each bit at mid-bit, and presents the assembled byte with a one-cycle valid strobe plus a framing-error strobe. It sits between the board RX pin and the CPU peripheral/MMIO receive register.

Parameters:
CLK_FREQ, 100000000, sysclk frequency in Hz
BAUD, 9600, line bit rate
OVERSAMPLE, 16, ticks per bit; must be even and at least 8
DIV, CLK_FREQ/(BAUD*OVERSAMPLE), sysclk cycles per tick; integer-truncated; must be at least 1

Ports:
sysclk  input  1  system clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  receiver enable; when low the block is held in IDLE
UART_RX  input  1  asynchronous serial line; idles high
RX_DATA  output  8  last correctly framed byte; held until the next good frame
rx_valid  output  1  one-cycle pulse when RX_DATA updates
frame_error  output  1  one-cycle pulse when the stop bit is sampled low
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (sysclk edge with reset=1) produces:
  - RX_DATA=0, rx_valid=0, frame_error=0, busy=0, state=IDLE
  - synchronizer flops=1, all counters=0
- Reset overrides everything, including mid-frame; the partial byte is discarded.
- Input sync: UART_RX passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- Tick generator:
  - counts 0..DIV-1 and asserts tick for 1 cycle at DIV-1
  - is held at 0 while in IDLE and restarts from 0 on the cycle of leaving IDLE
- tick_cnt counts ticks 0..OVERSAMPLE-1; bit_cnt is 3 bits.
- FSM:
  - IDLE: when enable=1 and rx_s=0, go to START and clear tick_cnt.
  - START: at tick number OVERSAMPLE/2 (mid start bit), check rx_s.
    - rx_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
    - rx_s=1: treat as a glitch and return to IDLE; no strobes.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into the MSB of the shift register (shift right), so that bit 0 is received first.
    - After the sample with bit_cnt=7, go to STOP; otherwise increment bit_cnt.
  - STOP: sample after OVERSAMPLE ticks.
    - rx_s=1: RX_DATA<=shift on the next edge, rx_valid=1 for exactly that cycle, then IDLE.
    - rx_s=0: frame_error=1 for 1 cycle; RX_DATA is unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s=1, then go to IDLE. This prevents a break condition from re-triggering the receiver.
- Because every byte ends at mid-stop-bit, a back-to-back start bit is detected with half a bit of margin.
- enable dropping to 0 in any state aborts to IDLE on the next edge; no strobes, RX_DATA unchanged.
- rx_valid and frame_error are never high in the same cycle.
- busy=0 only in IDLE; it is a registered output.
- Latency: the line falling edge of the start bit to rx_valid is about 9.5 bit times + 3 cycles.
- Tolerated baud mismatch is ±(OVERSAMPLE/2−1)/(OVERSAMPLE·10) of bit time. No error flag is raised for mismatch inside that bound.

Test Plan:
(Bench params: CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, giving DIV=10 and 160 cycles per bit.)
1. Reset then drive the frame 0x55 (start, 1,0,1,0,1,0,1,0, stop) at 160 cycles/bit -> one rx_valid pulse, RX_DATA=0x55, frame_error never set, busy returns to 0.
2. Send 0xA3 then 0x0F back-to-back with no idle gap -> two rx_valid pulses, about 1600 cycles apart, RX_DATA=0xA3 then 0x0F.
3. Send 0x3C with the stop bit held low, then return the line high -> frame_error pulses once, no rx_valid, RX_DATA keeps its previous value, FSM passes through WAIT_HIGH to IDLE.
4. Drive a 40-cycle low glitch on an idle line -> busy rises and then falls, no rx_valid or frame_error, state returns to IDLE before cycle 100.
5. Assert reset at the 4th data bit of 0xFF, then send 0x81 -> no strobe for the aborted frame, then rx_valid with RX_DATA=0x81.
6. Hold enable=0 while sending 0x12 -> no strobes, busy=0. Then enable=1 and send 0x34 at 154 cycles/bit (−3.75%) -> rx_valid with RX_DATA=0x34.
